// File: rtl/freq_scan_scheduler.sv
// freq_scan_scheduler
// Time-shares a single FreqCounter16P across NUM_CH 16-sample feedback inputs.
// Unmasked channels are visited round-robin; each dwell averages PERIODS
// counter periods (or gives up after TIMEOUT clocks in MEASURE) and produces
// one result on a valid/ready handshake. Backpressure stalls the scan.
// Optional build macro FREQ_SCAN_MINMAX_EN adds res_min/res_max outputs that
// carry the smallest/largest counter period seen within the dwell.
module freq_scan_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int PERIODS = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [NUM_CH*16-1:0]      samples_in,
  output logic [15:0]               cnt_in_p16,
  output logic                      cnt_reset,
  input  logic                      cnt_valid,
  input  logic [31:0]               cnt_period,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [31:0]               res_period,
`ifdef FREQ_SCAN_MINMAX_EN
  output logic                      res_timeout,
  output logic [31:0]               res_min,
  output logic [31:0]               res_max
`else
  output logic                      res_timeout
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LOG2P = $clog2(PERIODS);
  localparam int SUM_W = 32 + LOG2P;
  localparam int N_W   = $clog2(PERIODS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CLEAR,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic             clr_q, clr_d;        // second CLEAR cycle marker
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;
  logic [31:0]      res_period_q, res_period_d;
  logic             res_timeout_q, res_timeout_d;
`ifdef FREQ_SCAN_MINMAX_EN
  logic [31:0]      min_q, min_d, max_q, max_d;
  logic [31:0]      res_min_q, res_min_d, res_max_q, res_max_d;
  logic [31:0]      pmin, pmax;
`endif

  logic [15:0]      ch_word [NUM_CH];
  logic [CH_W-1:0]  next_ch;
  logic             next_found;
  logic [SUM_W-1:0] sum_acc;
  logic             done_now;
  logic             tmo_now;

  // Per-channel 16-sample slices; the counter sees the current channel's slice.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
    assign ch_word[gi] = samples_in[16*gi +: 16];
  end
  assign cnt_in_p16 = ch_word[cur_ch_q];

  assign sum_acc  = sum_q + SUM_W'(cnt_period);
  // The pulse that fills the dwell beats a coincident timeout.
  assign done_now = (state_q == S_MEASURE) && cnt_valid && (n_q == N_W'(PERIODS - 1));
  assign tmo_now  = (state_q == S_MEASURE) && !done_now && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Round-robin search: first set mask bit strictly after cur_ch, wrapping.
  always_comb begin
    int idx;
    next_ch    = cur_ch_q;
    next_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(cur_ch_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!next_found && ch_mask[CH_W'(idx)]) begin
        next_ch    = CH_W'(idx);
        next_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable && (|ch_mask)) state_d = S_SELECT;
      S_SELECT:  state_d = (|ch_mask) ? S_CLEAR : S_IDLE;
      S_CLEAR:   if (clr_q) state_d = S_MEASURE;
      S_MEASURE: if (done_now || tmo_now) state_d = S_REPORT;
      S_REPORT:  if (res_ready) state_d = enable ? S_SELECT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: counter held in reset except while measuring.
  always_comb begin
    cnt_reset = (state_q != S_MEASURE);
    res_valid = (state_q == S_REPORT);
  end

`ifdef FREQ_SCAN_MINMAX_EN
  // Running extremes including the current counter pulse.
  always_comb begin
    pmin = (cnt_period < min_q) ? cnt_period : min_q;
    pmax = (cnt_period > max_q) ? cnt_period : max_q;
  end
`endif

  // Datapath next state: channel pointer, accumulators and result registers.
  always_comb begin
    cur_ch_d      = cur_ch_q;
    clr_d         = clr_q;
    sum_d         = sum_q;
    n_d           = n_q;
    tmo_d         = tmo_q;
    res_ch_d      = res_ch_q;
    res_period_d  = res_period_q;
    res_timeout_d = res_timeout_q;
`ifdef FREQ_SCAN_MINMAX_EN
    min_d         = min_q;
    max_d         = max_q;
    res_min_d     = res_min_q;
    res_max_d     = res_max_q;
`endif
    case (state_q)
      S_SELECT: begin
        if (|ch_mask) cur_ch_d = next_ch;
        clr_d = 1'b0;
      end
      S_CLEAR: clr_d = ~clr_q;
      S_MEASURE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (cnt_valid) begin
          sum_d = sum_acc;
          n_d   = n_q + N_W'(1);
`ifdef FREQ_SCAN_MINMAX_EN
          min_d = pmin;
          max_d = pmax;
`endif
        end
        if (done_now) begin
          res_ch_d      = cur_ch_q;
          res_period_d  = sum_acc[31+LOG2P:LOG2P];
          res_timeout_d = 1'b0;
`ifdef FREQ_SCAN_MINMAX_EN
          res_min_d     = pmin;
          res_max_d     = pmax;
`endif
        end else if (tmo_now) begin
          res_ch_d      = cur_ch_q;
          res_period_d  = 32'd0;
          res_timeout_d = 1'b1;
`ifdef FREQ_SCAN_MINMAX_EN
          res_min_d     = 32'd0;
          res_max_d     = 32'd0;
`endif
        end
      end
      S_REPORT: begin
        // Accumulators clear on acceptance so the next dwell starts clean.
        if (res_ready) begin
          sum_d = '0;
          n_d   = '0;
          tmo_d = '0;
`ifdef FREQ_SCAN_MINMAX_EN
          min_d = 32'hFFFF_FFFF;
          max_d = 32'd0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset points the scan at the last channel so ch0 is first.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_ch_q      <= CH_W'(NUM_CH - 1);
      clr_q         <= 1'b0;
      sum_q         <= '0;
      n_q           <= '0;
      tmo_q         <= '0;
      res_ch_q      <= '0;
      res_period_q  <= '0;
      res_timeout_q <= 1'b0;
`ifdef FREQ_SCAN_MINMAX_EN
      min_q         <= 32'hFFFF_FFFF;
      max_q         <= 32'd0;
      res_min_q     <= 32'hFFFF_FFFF;
      res_max_q     <= 32'd0;
`endif
    end else begin
      cur_ch_q      <= cur_ch_d;
      clr_q         <= clr_d;
      sum_q         <= sum_d;
      n_q           <= n_d;
      tmo_q         <= tmo_d;
      res_ch_q      <= res_ch_d;
      res_period_q  <= res_period_d;
      res_timeout_q <= res_timeout_d;
`ifdef FREQ_SCAN_MINMAX_EN
      min_q         <= min_d;
      max_q         <= max_d;
      res_min_q     <= res_min_d;
      res_max_q     <= res_max_d;
`endif
    end
  end

  assign res_ch      = res_ch_q;
  assign res_period  = res_period_q;
  assign res_timeout = res_timeout_q;
`ifdef FREQ_SCAN_MINMAX_EN
  assign res_min     = res_min_q;
  assign res_max     = res_max_q;
`endif

endmodule

// File: tb/tb_freq_scan_scheduler.sv
// Testbench for freq_scan_scheduler: square-wave channel generators, a
// behavioural rising-edge period counter standing in for FreqCounter16P, and a
// scoreboard of expected results checked as each result is handed over.
module tb_freq_scan_scheduler;

  localparam int NUM_CH     = 4;
  localparam int PERIODS    = 4;
  localparam int TB_TIMEOUT = 1024;
`ifdef FREQ_SCAN_MINMAX_EN
  localparam int VW = 2 + 1 + 32 + 64;
`else
  localparam int VW = 2 + 1 + 32;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  ch_mask = 4'b0000;
  logic [63:0] samples_in = '0;
  logic [15:0] cnt_in_p16;
  logic        cnt_reset;
  logic        cnt_valid = 1'b0;
  logic [31:0] cnt_period = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [1:0]  res_ch;
  logic [31:0] res_period;
  logic        res_timeout;
`ifdef FREQ_SCAN_MINMAX_EN
  logic [31:0] res_min, res_max;
`endif
  logic [VW-1:0] got_vec;

  freq_scan_scheduler #(.NUM_CH(NUM_CH), .PERIODS(PERIODS), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .samples_in(samples_in), .cnt_in_p16(cnt_in_p16), .cnt_reset(cnt_reset),
    .cnt_valid(cnt_valid), .cnt_period(cnt_period), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_period(res_period),
`ifdef FREQ_SCAN_MINMAX_EN
    .res_timeout(res_timeout), .res_min(res_min), .res_max(res_max)
`else
    .res_timeout(res_timeout)
`endif
  );

`ifdef FREQ_SCAN_MINMAX_EN
  assign got_vec = {res_ch, res_timeout, res_period, res_min, res_max};
`else
  assign got_vec = {res_ch, res_timeout, res_period};
`endif

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          ch;
    logic [31:0] period;
    logic        tmo;
    logic [31:0] mn;
    logic [31:0] mx;
  } exp_t;
  exp_t sb[$];

  function automatic logic [VW-1:0] pack_exp(input exp_t e);
`ifdef FREQ_SCAN_MINMAX_EN
    return {2'(e.ch), e.tmo, e.period, e.mn, e.mx};
`else
    return {2'(e.ch), e.tmo, e.period};
`endif
  endfunction

  // Waveform tables: per channel a cycle of four period lengths (0 = constant low).
  int per_tab [4][4];
  int ph  [4];
  int idx [4];

  task automatic set_wave(input int c, input int p0, input int p1, input int p2, input int p3);
    per_tab[c][0] = p0; per_tab[c][1] = p1; per_tab[c][2] = p2; per_tab[c][3] = p3;
    ph[c] = 0; idx[c] = 0;
  endtask

  // Counter inputs as presented into the next rising edge.
  logic [15:0] cap_w;
  logic        cap_rst = 1'b1;
  initial forever begin
    @(negedge clock);
    cap_w   = cnt_in_p16;
    cap_rst = cnt_reset;
  end

  // Counter model (period reported as distance-1) followed by the sample generators.
  initial begin : gen
    bit          c_primed, c_prev, c_seen;
    int unsigned c_cnt, c_last;
    logic [63:0] nxt;
    int          p;
    c_primed = 0; c_prev = 0; c_seen = 0; c_cnt = 0; c_last = 0;
    forever begin
      @(posedge clock);
      #1;
      cnt_valid = 1'b0;
      if (cap_rst !== 1'b0) begin
        c_primed = 0; c_seen = 0; c_cnt = 0;
      end else begin
        for (int b = 0; b < 16; b++) begin
          if (c_primed && !c_prev && cap_w[b]) begin
            if (c_seen) begin
              cnt_valid  = 1'b1;
              cnt_period = c_cnt - c_last - 1;
            end
            c_last = c_cnt;
            c_seen = 1;
          end
          c_prev   = cap_w[b];
          c_primed = 1;
          c_cnt++;
        end
      end
      nxt = '0;
      for (int c = 0; c < 4; c++) begin
        for (int b = 0; b < 16; b++) begin
          p = per_tab[c][idx[c]];
          nxt[16*c+b] = (p != 0) && (ph[c] < p / 2);
          if (p != 0) begin
            ph[c]++;
            if (ph[c] >= p) begin
              ph[c]  = 0;
              idx[c] = (idx[c] + 1) % 4;
            end
          end
        end
      end
      samples_in = nxt;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit found);
    int i;
    found = 0;
    i = 0;
    while (!found && i < budget) begin
      @(negedge clock);
      i++;
      if (res_valid === 1'b1) found = 1;
    end
  endtask

  task automatic wait_measure(input int budget, output bit found);
    int i;
    found = 0;
    i = 0;
    while (!found && i < budget) begin
      @(negedge clock);
      i++;
      if (cnt_reset === 1'b0) found = 1;
    end
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; ch_mask = 4'b0001;
    repeat (2) @(negedge clock);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", res_valid); end
    n_checks++; if (cnt_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_reset: got %b exp 1", cnt_reset); end
    n_checks++; if (res_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", res_timeout); end
    n_checks++; if (res_period !== 32'd0) begin n_fail++; $display("FAIL reset_period: got %0d exp 0", res_period); end
    n_checks++; if (res_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d exp 0", res_ch); end
    n_checks++; if (cnt_in_p16 !== samples_in[63:48]) begin n_fail++; $display("FAIL reset_mux_ch3: got %h exp %h", cnt_in_p16, samples_in[63:48]); end
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (cnt_reset !== 1'b1 || res_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_hold: %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_single_channel();
    bit found; exp_t e;
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1; res_ready = 1'b1;
    repeat (3) sb.push_back('{0, 32'd99, 1'b0, 32'd99, 32'd99});
    for (int k = 0; k < 3; k++) begin
      wait_res(400, found);
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL single_wait[%0d]: no res_valid exp result", k); end
      else begin
        e = sb.pop_front();
        if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL single_result[%0d]: got %h exp %h", k, got_vec, pack_exp(e)); end
        @(posedge clock);
      end
    end
  endtask

  task automatic test_two_channels();
    bit found; exp_t e;
    do_reset();
    ch_mask = 4'b1010; enable = 1'b1; res_ready = 1'b1;
    repeat (2) begin
      sb.push_back('{1, 32'd63, 1'b0, 32'd63, 32'd63});
      sb.push_back('{3, 32'd199, 1'b0, 32'd199, 32'd199});
    end
    for (int k = 0; k < 4; k++) begin
      wait_res(400, found);
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL two_wait[%0d]: no res_valid exp result", k); end
      else begin
        e = sb.pop_front();
        if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL two_result[%0d]: got %h exp %h", k, got_vec, pack_exp(e)); end
        @(posedge clock);
      end
    end
  endtask

  task automatic test_timeout();
    bit found; exp_t e; int a, b;
    do_reset();
    ch_mask = 4'b0100; enable = 1'b1; res_ready = 1'b1;
    sb.push_back('{2, 32'd0, 1'b1, 32'd0, 32'd0});
    wait_measure(50, found);
    a = cyc;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL tmo_enter: MEASURE not entered"); end
    wait_res(TB_TIMEOUT + 50, found);
    b = cyc;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL tmo_wait: no res_valid exp timeout result"); end
    else begin
      n_checks++;
      if (b - a != TB_TIMEOUT) begin n_fail++; $display("FAIL tmo_latency: got %0d exp %0d", b - a, TB_TIMEOUT); end
      e = sb.pop_front();
      if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL tmo_result: got %h exp %h", got_vec, pack_exp(e)); end
      @(posedge clock);
    end
  endtask

  task automatic test_backpressure();
    bit found; exp_t e; int bad;
    do_reset();
    ch_mask = 4'b0011; enable = 1'b1; res_ready = 1'b0;
    sb.push_back('{0, 32'd99, 1'b0, 32'd99, 32'd99});
    sb.push_back('{1, 32'd63, 1'b0, 32'd63, 32'd63});
    wait_res(400, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bp_wait: no res_valid exp result"); end
    else begin
      e = sb.pop_front();
      if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL bp_result: got %h exp %h", got_vec, pack_exp(e)); end
      bad = 0;
      repeat (50) begin
        @(negedge clock);
        if (res_valid !== 1'b1 || cnt_reset !== 1'b1 || got_vec !== pack_exp(e)) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles exp 0", bad); end
      res_ready = 1'b1;
      @(negedge clock);
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: res_valid got %b exp 0", res_valid); end
      wait_res(400, found);
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL bp_next_wait: no res_valid exp ch1 result"); end
      else begin
        e = sb.pop_front();
        if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL bp_next: got %h exp %h", got_vec, pack_exp(e)); end
        @(posedge clock);
      end
    end
  endtask

  task automatic test_reset_mid_measure();
    bit found; exp_t e;
    do_reset();
    ch_mask = 4'b0011; enable = 1'b1; res_ready = 1'b1;
    wait_res(400, found);
    @(posedge clock);
    wait_measure(50, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_mid_enter: second MEASURE not entered"); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (res_valid !== 1'b0 || cnt_reset !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state: valid/cnt_reset got %b%b exp 01", res_valid, cnt_reset);
    end
    reset = 1'b0;
    sb.delete();
    sb.push_back('{0, 32'd99, 1'b0, 32'd99, 32'd99});
    wait_res(400, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_mid_wait: no res_valid exp ch0 result"); end
    else begin
      e = sb.pop_front();
      if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL rst_mid_first: got %h exp %h", got_vec, pack_exp(e)); end
      @(posedge clock);
    end
  endtask

  task automatic test_enable_stop();
    bit found; exp_t e; int bad;
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1; res_ready = 1'b1;
    wait_measure(50, found);
    enable = 1'b0;
    sb.push_back('{0, 32'd99, 1'b0, 32'd99, 32'd99});
    wait_res(400, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL en_stop_wait: no res_valid exp final result"); end
    else begin
      e = sb.pop_front();
      if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL en_stop_result: got %h exp %h", got_vec, pack_exp(e)); end
      @(posedge clock);
      bad = 0;
      repeat (100) begin
        @(negedge clock);
        if (cnt_reset !== 1'b1 || res_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL en_stop_idle: %0d active cycles exp 0", bad); end
    end
    enable = 1'b1;
  endtask

`ifdef FREQ_SCAN_MINMAX_EN
  task automatic test_minmax();
    bit found; exp_t e;
    set_wave(0, 100, 102, 98, 100);
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1; res_ready = 1'b1;
    repeat (2) sb.push_back('{0, 32'd99, 1'b0, 32'd97, 32'd101});
    for (int k = 0; k < 2; k++) begin
      wait_res(400, found);
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL minmax_wait[%0d]: no res_valid exp result", k); end
      else begin
        e = sb.pop_front();
        if (got_vec !== pack_exp(e)) begin n_fail++; $display("FAIL minmax_result[%0d]: got %h exp %h", k, got_vec, pack_exp(e)); end
        @(posedge clock);
      end
    end
    set_wave(0, 100, 100, 100, 100);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_wave(0, 100, 100, 100, 100);
    set_wave(1, 64, 64, 64, 64);
    set_wave(2, 0, 0, 0, 0);
    set_wave(3, 200, 200, 200, 200);
    test_reset();
    test_single_channel();
    test_two_channels();
    test_timeout();
    test_backpressure();
    test_reset_mid_measure();
    test_enable_stop();
`ifdef FREQ_SCAN_MINMAX_EN
    test_minmax();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
